mmio_wait_ctrl: RTL and testbench

MMIO_WAIT_CTRL -- requirements
Module: mmio_wait_ctrl

---
 rtl/mmio_pkg.sv | 16 +
 rtl/mmio_err_status.sv | 66 ++++++
 rtl/mmio_wait_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mmio_wait_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO wait-state controller.
package mmio_pkg;

   localparam int          DATA_W     = 32;
   localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
   localparam int          STAT_ERR   = 0;
   localparam int          STAT_TOCNT = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mmio_err_status.sv
// Timeout error flags, first-error capture and saturating timeout count,
// exposed as the controller's internal status slot.
module mmio_err_status
   import mmio_pkg::*;
#(
   parameter int SLOT_AW = 6,
   parameter int REG_AW  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               to_event,
   input  logic [SLOT_AW-1:0] to_slot,
   input  logic               to_wr,
   input  logic               wr_en,
   input  logic [REG_AW-1:0]  wr_reg,
   input  logic               wr_bit0,
   input  logic [REG_AW-1:0]  rd_reg,
   output logic [31:0]        rd_data,
   output logic               err_irq
);

   logic               to_flag;
   logic [SLOT_AW-1:0] err_slot;
   logic               err_wr;
   logic [15:0]        to_cnt;
   logic [7:0]         err_slot8;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_flag  <= 1'b0;
         err_slot <= '0;
         err_wr   <= 1'b0;
         to_cnt   <= '0;
      end else if (to_event) begin
         // Only the first timeout since the last clear is recorded.
         if (!to_flag) begin
            err_slot <= to_slot;
            err_wr   <= to_wr;
         end
         to_flag <= 1'b1;
         if (to_cnt != 16'hFFFF)
            to_cnt <= to_cnt + 16'd1;
      end else if (wr_en) begin
         if (wr_reg == REG_AW'(STAT_ERR) && wr_bit0) begin
            to_flag  <= 1'b0;
            err_slot <= '0;
            err_wr   <= 1'b0;
         end else if (wr_reg == REG_AW'(STAT_TOCNT)) begin
            to_cnt <= '0;
         end
      end
   end

   assign err_slot8 = 8'(err_slot);

   always_comb begin
      rd_data = '0;
      if (rd_reg == REG_AW'(STAT_ERR))
         rd_data = {15'b0, err_wr, err_slot8, 7'b0, to_flag};
      else if (rd_reg == REG_AW'(STAT_TOCNT))
         rd_data = {16'b0, to_cnt};
   end

   assign err_irq = to_flag;

endmodule

// File: rtl/mmio_wait_ctrl.sv
// MMIO bridge fanning one bus master out to N_SLOT slots with per-access
// wait states, a bounded timeout, and an internal status slot.
module mmio_wait_ctrl
   import mmio_pkg::*;
#(
   parameter int N_SLOT  = 64,
   parameter int SLOT_AW = 6,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mmio_cs,
   input  logic                   mmio_wr,
   input  logic                   mmio_rd,
   input  logic [20:0]            mmio_addr,
   input  logic [31:0]            mmio_wr_data,
   output logic [31:0]            mmio_rd_data,
   output logic                   mmio_ready,
   output logic [N_SLOT-1:0]      slot_cs_array,
   output logic [N_SLOT-1:0]      slot_mem_rd_array,
   output logic [N_SLOT-1:0]      slot_mem_wr_array,
   output logic [REG_AW-1:0]      slot_reg_addr,
   output logic [31:0]            slot_wr_data,
   input  logic [N_SLOT*32-1:0]   slot_rd_data_array,
   input  logic [N_SLOT-1:0]      slot_ready_array,
   output logic                   err_irq
);

   localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [SLOT_AW-1:0] slot_q;
   logic [REG_AW-1:0]  reg_q;
   logic               wr_q;
   logic [31:0]        wdata_q;
   logic [31:0]        rd_q;
   logic [15:0]        wait_cnt;

   logic               req;
   logic               is_status;
   logic               sel_ready;
   logic [31:0]        sel_data;
   logic               to_event;
   logic               stat_wr;
   logic [31:0]        stat_rd;
   logic               unused_addr;

   assign req         = mmio_cs & (mmio_wr | mmio_rd);
   assign is_status   = (slot_q == SLOT_AW'(N_SLOT - 1));
   assign unused_addr = ^mmio_addr[20:REG_AW+SLOT_AW];

   // Indices >= N_SLOT match nothing here, so they see no ready and time out.
   always_comb begin
      sel_ready = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < N_SLOT; i++) begin
         if (slot_q == SLOT_AW'(i)) begin
            sel_ready = slot_ready_array[i] & ~is_status;
            sel_data  = slot_rd_data_array[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      to_event = 1'b0;
      case (state_q)
         IDLE:   if (req) state_d = ACCESS;
         ACCESS: state_d = (is_status || sel_ready) ? DONE : WAIT;
         WAIT: begin
            if (sel_ready) begin
               state_d = DONE;
            end else if (wait_cnt == TIMEOUT_M1) begin
               state_d  = DONE;
               to_event = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q   <= '0;
         reg_q    <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         rd_q     <= '0;
         wait_cnt <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  slot_q  <= mmio_addr[REG_AW +: SLOT_AW];
                  reg_q   <= mmio_addr[REG_AW-1:0];
                  wr_q    <= mmio_wr;
                  wdata_q <= mmio_wr_data;
               end
            end
            ACCESS: begin
               wait_cnt <= '0;
               if (is_status)
                  rd_q <= wr_q ? 32'h0 : stat_rd;
               else if (sel_ready)
                  rd_q <= wr_q ? 32'h0 : sel_data;
            end
            WAIT: begin
               if (sel_ready)
                  rd_q <= wr_q ? 32'h0 : sel_data;
               else if (to_event)
                  rd_q <= ERR_DATA;
               else
                  wait_cnt <= wait_cnt + 16'd1;
            end
            DONE:    rd_q <= '0;
            default: rd_q <= '0;
         endcase
      end
   end

   always_comb begin
      slot_cs_array     = '0;
      slot_mem_rd_array = '0;
      slot_mem_wr_array = '0;
      for (int i = 0; i < N_SLOT - 1; i++) begin
         if (slot_q == SLOT_AW'(i)) begin
            slot_cs_array[i]     = (state_q == ACCESS) || (state_q == WAIT);
            slot_mem_rd_array[i] = (state_q == ACCESS) && !wr_q;
            slot_mem_wr_array[i] = (state_q == ACCESS) && wr_q;
         end
      end
   end

   assign slot_reg_addr = reg_q;
   assign slot_wr_data  = wdata_q;
   assign mmio_ready    = (state_q == DONE);
   assign mmio_rd_data  = rd_q;

   // Status writes land at the end of DONE, so err_irq drops the cycle after.
   assign stat_wr = (state_q == DONE) && is_status && wr_q;

   mmio_err_status #(
      .SLOT_AW (SLOT_AW),
      .REG_AW  (REG_AW)
   ) u_err_status (
      .clk      (clk),
      .reset    (reset),
      .to_event (to_event),
      .to_slot  (slot_q),
      .to_wr    (wr_q),
      .wr_en    (stat_wr),
      .wr_reg   (reg_q),
      .wr_bit0  (wdata_q[0]),
      .rd_reg   (reg_q),
      .rd_data  (stat_rd),
      .err_irq  (err_irq)
   );

endmodule

// File: tb/tb_mmio_wait_ctrl.sv
// Directed bench for mmio_wait_ctrl with a transaction-level reference model.
module tb_mmio_wait_ctrl;

   localparam int N_SLOT  = 48;
   localparam int SLOT_AW = 6;
   localparam int REG_AW  = 5;
   localparam int TIMEOUT = 16;
   localparam int STAT    = N_SLOT - 1;
   localparam logic [N_SLOT-1:0] ONE = (N_SLOT)'(1);

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  mmio_cs, mmio_wr, mmio_rd;
   logic [20:0]           mmio_addr;
   logic [31:0]           mmio_wr_data;
   logic [31:0]           mmio_rd_data;
   logic                  mmio_ready;
   logic [N_SLOT-1:0]     slot_cs_array, slot_mem_rd_array, slot_mem_wr_array;
   logic [REG_AW-1:0]     slot_reg_addr;
   logic [31:0]           slot_wr_data;
   logic [N_SLOT*32-1:0]  slot_rd_data_array;
   logic [N_SLOT-1:0]     slot_ready_array;
   logic                  err_irq;

   mmio_wait_ctrl #(
      .N_SLOT (N_SLOT), .SLOT_AW (SLOT_AW), .REG_AW (REG_AW), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .mmio_cs            (mmio_cs),
      .mmio_wr            (mmio_wr),
      .mmio_rd            (mmio_rd),
      .mmio_addr          (mmio_addr),
      .mmio_wr_data       (mmio_wr_data),
      .mmio_rd_data       (mmio_rd_data),
      .mmio_ready         (mmio_ready),
      .slot_cs_array      (slot_cs_array),
      .slot_mem_rd_array  (slot_mem_rd_array),
      .slot_mem_wr_array  (slot_mem_wr_array),
      .slot_reg_addr      (slot_reg_addr),
      .slot_wr_data       (slot_wr_data),
      .slot_rd_data_array (slot_rd_data_array),
      .slot_ready_array   (slot_ready_array),
      .err_irq            (err_irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: current transaction window and status-slot contents.
   bit          active = 1'b0;
   int          t_req = -10, t_done = -10, ready_from = -1;
   int          m_slot = 0, m_reg = 0;
   bit          m_wr, m_ext, m_status, m_timeout;
   logic [31:0] m_data = '0;
   bit          m_to = 1'b0, m_ewr = 1'b0;
   int          m_eslot = 0;
   int          m_tocnt = 0;

   int          ready_pulses = 0;
   int          last_done_cyc = 0;
   logic [31:0] last_rd = '0;

   function automatic logic [31:0] slot_word(input int i);
      if (i == 3) return 32'h1234_5678;
      return 32'hA000_0000 + 32'(i) * 32'h0001_0011;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slot responder: target slot raises ready from ready_from onward; slot 10 is a decoy.
   always_comb begin
      slot_ready_array = '0;
      slot_ready_array[10] = 1'b1;
      if (active && ready_from >= 0 && cyc >= ready_from)
         slot_ready_array = slot_ready_array | (ONE << m_slot);
   end

   logic [N_SLOT-1:0] e_rd, e_wr, e_cs;
   logic [31:0]       exp_d;
   bit                at_done;

   always @(negedge clk) begin
      if (reset) begin
         at_done = active && (cyc == t_done);
         e_rd = '0; e_wr = '0; e_cs = '0;
         if (active && m_ext) begin
            if (cyc == t_req + 1) begin
               if (m_wr) e_wr = ONE << m_slot;
               else      e_rd = ONE << m_slot;
            end
            if (cyc > t_req && cyc < t_done) e_cs = ONE << m_slot;
         end
         check("mmio_ready", 64'(mmio_ready), 64'(at_done));
         check("slot_cs", 64'(slot_cs_array), 64'(e_cs));
         check("rd_strobe", 64'(slot_mem_rd_array), 64'(e_rd));
         check("wr_strobe", 64'(slot_mem_wr_array), 64'(e_wr));
         if (e_cs != '0) begin
            check("slot_reg_addr", 64'(slot_reg_addr), 64'(m_reg));
            check("slot_wr_data", 64'(slot_wr_data), 64'(m_data));
         end
         if (mmio_ready) begin
            ready_pulses++;
            last_rd = mmio_rd_data;
            last_done_cyc = cyc;
         end
         if (at_done) begin
            if (m_timeout) begin
               if (!m_to) begin
                  m_eslot = m_slot;
                  m_ewr   = m_wr;
               end
               m_to = 1'b1;
               if (m_tocnt < 65535) m_tocnt++;
            end
            if (m_timeout)      exp_d = 32'hDEAD_BEEF;
            else if (m_wr)      exp_d = 32'h0;
            else if (m_status) begin
               if (m_reg == 0)      exp_d = (32'(m_ewr) << 16) | (32'(m_eslot) << 8) | 32'(m_to);
               else if (m_reg == 1) exp_d = 32'(m_tocnt);
               else                 exp_d = 32'h0;
            end else            exp_d = slot_word(m_slot);
            check("mmio_rd_data", 64'(mmio_rd_data), 64'(exp_d));
         end
         check("err_irq", 64'(err_irq), 64'(m_to));
         if (at_done && m_status && m_wr) begin
            if (m_reg == 0 && m_data[0]) begin
               m_to = 1'b0; m_eslot = 0; m_ewr = 1'b0;
            end else if (m_reg == 1) begin
               m_tocnt = 0;
            end
         end
      end
   end

   task automatic idle_bus();
      mmio_cs = 1'b0; mmio_wr = 1'b0; mmio_rd = 1'b0;
      mmio_addr = 21'h1F_FFFF; mmio_wr_data = 32'hFFFF_FFFF;
   endtask

   // op: 0 read, 1 write, 2 both qualifiers (write). k: ready delay after strobe, -1 never.
   task automatic start_txn(input int slot, input int rg, input int op, input logic [31:0] d, input int k);
      @(posedge clk); #1;
      t_req     = cyc;
      m_slot    = slot;
      m_reg     = rg;
      m_wr      = (op != 0);
      m_data    = d;
      m_status  = (slot == STAT);
      m_ext     = (slot < STAT);
      m_timeout = !m_status && !(m_ext && k >= 0 && k <= TIMEOUT);
      if (m_status)       t_done = t_req + 2;
      else if (m_timeout) t_done = t_req + 2 + TIMEOUT;
      else                t_done = t_req + 2 + k;
      ready_from = (m_ext && k >= 0) ? t_req + 1 + k : -1;
      active    = 1'b1;
      mmio_cs   = 1'b1;
      mmio_wr   = (op != 0);
      mmio_rd   = (op != 1);
      mmio_addr = {10'h2A5, 6'(slot), 5'(rg)};
      mmio_wr_data = d;
      @(posedge clk); #1;
      idle_bus();
   endtask

   task automatic run_txn(input int slot, input int rg, input int op, input logic [31:0] d,
                          input int k, input bit ghost);
      start_txn(slot, rg, op, d, k);
      if (ghost) begin
         repeat (2) @(posedge clk);
         #1;
         mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_addr = {10'h0, 6'd4, 5'd1};
         @(posedge clk); #1;
         idle_bus();
      end
      repeat (t_done - cyc + 1) @(posedge clk);
      #1;
      active = 1'b0;
   endtask

   int pulses0;

   initial begin
      reset = 1'b0;
      idle_bus();
      slot_rd_data_array = '0;
      for (int i = 0; i < N_SLOT; i++)
         slot_rd_data_array = slot_rd_data_array | ((N_SLOT*32)'(slot_word(i)) << (32*i));
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(mmio_ready), 64'h0);
      check("rst_rd_data", 64'(mmio_rd_data), 64'h0);
      check("rst_cs", 64'(slot_cs_array), 64'h0);
      check("rst_err_irq", 64'(err_irq), 64'h0);
      reset = 1'b1;
      repeat (2) @(posedge clk);

      run_txn(3, 2, 0, 32'h0, 0, 0);
      check("lat_read", 64'(last_done_cyc - t_req), 64'd2);
      check("data_read", 64'(last_rd), 64'h1234_5678);

      run_txn(9, 1, 1, 32'hA5A5_0001, 4, 0);
      check("lat_write", 64'(last_done_cyc - t_req), 64'd6);
      check("data_write", 64'(last_rd), 64'h0);

      run_txn(7, 0, 0, 32'h0, -1, 0);
      check("lat_timeout", 64'(last_done_cyc - t_req), 64'd18);
      check("data_timeout", 64'(last_rd), 64'hDEAD_BEEF);
      check("irq_after_to", 64'(err_irq), 64'h1);

      run_txn(STAT, 0, 0, 32'h0, 0, 0);
      check("stat_reg0", 64'(last_rd), 64'h0000_0701);
      check("lat_status", 64'(last_done_cyc - t_req), 64'd2);

      run_txn(STAT, 0, 1, 32'h1, 0, 0);
      check("irq_after_w1c", 64'(err_irq), 64'h0);
      run_txn(STAT, 0, 0, 32'h0, 0, 0);
      check("stat_reg0_clr", 64'(last_rd), 64'h0);
      run_txn(STAT, 1, 0, 32'h0, 0, 0);
      check("stat_reg1_one", 64'(last_rd), 64'h1);

      run_txn(12, 4, 2, 32'h0BAD_F00D, TIMEOUT, 0);
      check("lat_last_wait", 64'(last_done_cyc - t_req), 64'd18);
      check("irq_no_to", 64'(err_irq), 64'h0);

      run_txn(20, 3, 1, 32'h0000_5555, TIMEOUT + 1, 0);
      run_txn(50, 0, 0, 32'h0, 0, 0);
      check("data_oob", 64'(last_rd), 64'hDEAD_BEEF);
      run_txn(STAT, 0, 0, 32'h0, 0, 0);
      check("stat_keep_first", 64'(last_rd), 64'h0001_1401);
      run_txn(STAT, 1, 0, 32'h0, 0, 0);
      check("stat_count3", 64'(last_rd), 64'h3);

      run_txn(STAT, 0, 1, 32'h0, 0, 0);
      run_txn(STAT, 5, 1, 32'hFFFF_FFFF, 0, 0);
      run_txn(STAT, 0, 0, 32'h0, 0, 0);
      check("stat_no_clear", 64'(last_rd), 64'h0001_1401);
      run_txn(STAT, 1, 1, 32'h0, 0, 0);
      run_txn(STAT, 1, 0, 32'h0, 0, 0);
      check("stat_cnt_clr", 64'(last_rd), 64'h0);

      pulses0 = ready_pulses;
      run_txn(2, 6, 0, 32'h0, 5, 1);
      check("ghost_pulses", 64'(ready_pulses - pulses0), 64'd1);
      check("ghost_data", 64'(last_rd), 64'(slot_word(2)));

      start_txn(5, 0, 0, 32'h0, -1);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      active = 1'b0;
      #1;
      check("abort_ready", 64'(mmio_ready), 64'h0);
      check("abort_rd_data", 64'(mmio_rd_data), 64'h0);
      check("abort_cs", 64'(slot_cs_array), 64'h0);
      check("abort_strobes", 64'({slot_mem_rd_array, slot_mem_wr_array}), 64'h0);
      check("abort_irq", 64'(err_irq), 64'h0);
      m_to = 1'b0; m_eslot = 0; m_ewr = 1'b0; m_tocnt = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      pulses0 = ready_pulses;
      repeat (20) @(posedge clk);
      #1;
      check("no_ready_after_rst", 64'(ready_pulses - pulses0), 64'd0);
      run_txn(4, 7, 0, 32'h0, 1, 0);
      check("post_rst_lat", 64'(last_done_cyc - t_req), 64'd3);
      check("post_rst_data", 64'(last_rd), 64'(slot_word(4)));
      run_txn(STAT, 1, 0, 32'h0, 0, 0);
      check("post_rst_cnt", 64'(last_rd), 64'h0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
